// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/busy/done request bus and BCD result bus of the converter
interface bin_to_bcd_seq_if #(
    parameter int IN_W = 7,
    parameter int DIGITS = 2
);
    logic START;
    logic [IN_W-1:0] NUMBER;
    logic BUSY;
    logic DONE;
    logic [4*DIGITS-1:0] BCD;
    logic [DIGITS-1:0] BLANK;
    logic OVF;
    modport master (output START, NUMBER, input BUSY, DONE, BCD, BLANK, OVF);
    modport slave (input START, NUMBER, output BUSY, DONE, BCD, BLANK, OVF);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock shift-and-add-3 binary to BCD converter
// with leading-zero blanking and an out-of-range flag.
module bin_to_bcd_seq #(
    parameter int IN_W = 7,
    parameter int DIGITS = 2,
    parameter bit BLANK_LZ = 1
) (
    input logic CLK,
    input logic RST,
    bin_to_bcd_seq_if.slave bus
);
    localparam int SW = 4*DIGITS+4;
    localparam int CW = $clog2(IN_W+1);
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
    state_t state_q, state_d;
    logic [IN_W-1:0] sr_q, sr_d;
    logic [SW-1:0] scr_q, scr_d, adj;
    logic [CW-1:0] cnt_q, cnt_d;
    logic sticky_q, sticky_d;
    logic done_q, done_d;
    logic ovf_q, ovf_d, ovf_c, z;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0] blank_q, blank_d, blk;
    always_comb begin
        state_d = state_q;
        sr_d = sr_q;
        scr_d = scr_q;
        cnt_d = cnt_q;
        sticky_d = sticky_q;
        done_d = 1'b0;
        bcd_d = bcd_q;
        blank_d = blank_q;
        ovf_d = ovf_q;
        adj = scr_q;
        for (int i = 0; i <= DIGITS; i++)
            if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        // a bit lost off the top of the scratch also means the value is out of range
        ovf_c = sticky_q || (scr_q[SW-1 -: 4] != 4'd0);
        blk = '0;
        z = 1'b1;
        for (int i = DIGITS-1; i >= 1; i--) begin
            z = z && (scr_q[4*i +: 4] == 4'd0);
            blk[i] = z;
        end
        case (state_q)
            IDLE: if (bus.START) begin
                sr_d = bus.NUMBER;
                scr_d = '0;
                cnt_d = CW'(IN_W);
                sticky_d = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                scr_d = {adj[SW-2:0], sr_q[IN_W-1]};
                sr_d = sr_q << 1;
                sticky_d = sticky_q || adj[SW-1];
                cnt_d = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? FINISH : SHIFT;
            end
            FINISH: begin
                done_d = 1'b1;
                ovf_d = ovf_c;
                bcd_d = ovf_c ? '0 : scr_q[4*DIGITS-1:0];
                blank_d = (ovf_c || !BLANK_LZ) ? '0 : blk;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sr_q <= '0;
            scr_q <= '0;
            cnt_q <= '0;
            sticky_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q <= '0;
            blank_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q <= sr_d;
            scr_q <= scr_d;
            cnt_q <= cnt_d;
            sticky_q <= sticky_d;
            done_q <= done_d;
            bcd_q <= bcd_d;
            blank_q <= blank_d;
            ovf_q <= ovf_d;
        end
    end
    assign bus.BUSY = state_q != IDLE;
    assign bus.DONE = done_q;
    assign bus.BCD = bcd_q;
    assign bus.BLANK = blank_q;
    assign bus.OVF = ovf_q;
endmodule
